time_pulse_gen: RTL

//  Consumer end of the timer phase interface: counts timer ct strobes and steps one-hot time pulses T01..T12

---
 rtl/time_pulse_gen_pkg.sv | 14 +
 rtl/tp_period_checker.sv | 46 ++++
 rtl/time_pulse_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/time_pulse_gen_pkg.sv
// Shared definitions for the time pulse generator and its clients:
// state encoding and default sizing.
package time_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } tpg_state_e;

  localparam int unsigned NUM_TP_DEF    = 12;
  localparam int unsigned CT_PERIOD_DEF = 2;

endpackage

// File: rtl/tp_period_checker.sv
// Measures clocks between ct strobes and raises a sticky flag
// when a strobe seen in RUN arrives off the expected period.
module tp_period_checker #(
  parameter int unsigned CT_PERIOD = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic ct,
  input  logic run,
  output logic err
);

  localparam int unsigned W = $clog2(CT_PERIOD + 2) + 1;
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] PER     = W'(CT_PERIOD);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  // cnt_q holds the clock distance to the previous strobe.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (ct) begin
      cnt_d = W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (ct && run && (cnt_q != PER)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/time_pulse_gen.sv
// Steps one-hot time pulses through each memory cycle time.
// Optional period checker enabled by TPG_PHASE_CHECK_EN.
module time_pulse_gen
  import time_pulse_gen_pkg::*;
#(
  parameter int unsigned NUM_TP    = NUM_TP_DEF,
  parameter int unsigned CT_PERIOD = CT_PERIOD_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              ct,
  input  logic              start,
  input  logic              hold_req,
  output logic [NUM_TP-1:0] tp,
  output logic              mct,
  output logic              stop,
  output logic              running,
  output logic              tp_err
);

  localparam logic [NUM_TP-1:0] TP_FIRST =
    {{(NUM_TP-1){1'b0}}, 1'b1};

  if (NUM_TP < 2 || NUM_TP > 16 || CT_PERIOD < 1) begin : g_bad_param
    $error("time_pulse_gen: illegal parameters");
  end

  tpg_state_e        state_q, state_d;
  logic [NUM_TP-1:0] tp_q, tp_d;
  logic              mct_q, mct_d;
  logic              stop_q, run_q;

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    mct_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ct && start) begin
          state_d = ST_RUN;
          tp_d    = TP_FIRST;
        end
      end
      ST_RUN: begin
        if (ct && tp_q[NUM_TP-1]) begin
          mct_d = 1'b1;
          if (hold_req) begin
            state_d = ST_HOLD;
            tp_d    = '0;
          end else if (!start) begin
            state_d = ST_IDLE;
            tp_d    = '0;
          end else begin
            tp_d = TP_FIRST;
          end
        end else if (ct) begin
          tp_d = tp_q << 1;
        end
      end
      ST_HOLD: begin
        if (!hold_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tp_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tp_q    <= '0;
      mct_q   <= 1'b0;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      mct_q   <= mct_d;
      stop_q  <= (state_d == ST_HOLD);
      run_q   <= |tp_d;
    end
  end

  assign tp      = tp_q;
  assign mct     = mct_q;
  assign stop    = stop_q;
  assign running = run_q;

`ifdef TPG_PHASE_CHECK_EN
  tp_period_checker #(
    .CT_PERIOD(CT_PERIOD)
  ) u_chk (
    .clock(clock),
    .rst  (rst),
    .ct   (ct),
    .run  (state_q == ST_RUN),
    .err  (tp_err)
  );
`else
  assign tp_err = 1'b0;
`endif

endmodule
